// File: rtl/rtc_time_set_ctrl.sv
// Time-set sequencer for the 24h RTC: edits hours then minutes in BCD and issues a one-cycle load.
// Optional edit timeout is compiled in with `define RTC_SET_TIMEOUT_EN.
module rtc_time_set_ctrl #(
  parameter int unsigned BLINK_DIV      = 25_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 250_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode_btn,
  input  logic       inc_btn,
  input  logic       dec_btn,
  input  logic       cancel_btn,
  input  logic [7:0] cur_hh,
  input  logic [7:0] cur_mm,
  output logic       run_en,
  output logic       load,
  output logic [7:0] load_hh,
  output logic [7:0] load_mm,
  output logic [7:0] load_ss,
  output logic [1:0] edit_field,
  output logic       blink
);

  typedef enum logic [1:0] {RUN, SET_HR, SET_MIN, COMMIT} state_t;

  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  state_t        state;
  logic [BW-1:0] blink_cnt;
  logic          timeout;
  logic          abort;
  logic          step;
  logic          bump;

  assign load_ss = 8'h00;
  assign step    = inc_btn ^ dec_btn;
  assign bump    = inc_btn | dec_btn;
  assign abort   = cancel_btn | timeout;

  // Any captured value that is not legal BCD within range is replaced by zero.
  function automatic logic [7:0] sanitize(input logic [7:0] v, input logic [7:0] max);
    if (v[7:4] > 4'd9 || v[3:0] > 4'd9 || v > max) return 8'h00;
    return v;
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    if (v == max)         return 8'h00;
    if (v[3:0] == 4'd9)   return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max);
    if (v == 8'h00)       return max;
    if (v[3:0] == 4'd0)   return {v[7:4] - 4'd1, 4'd9};
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

`ifdef RTC_SET_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] idle_cnt;
  logic          editing;

  assign editing = (state == SET_HR) || (state == SET_MIN);
  assign timeout = editing && (idle_cnt == IDLE_LAST) && !(mode_btn | inc_btn | dec_btn);

  always_ff @(posedge clk) begin
    if (rst || !editing || mode_btn || inc_btn || dec_btn || timeout) idle_cnt <= '0;
    else                                                              idle_cnt <= idle_cnt + 1'b1;
  end
`else
  // TIMEOUT_CYCLES is >=1, so this is a constant zero: edits never expire in this build.
  assign timeout = (TIMEOUT_CYCLES == 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      run_en     <= 1'b1;
      load       <= 1'b0;
      load_hh    <= 8'h00;
      load_mm    <= 8'h00;
      edit_field <= 2'd0;
      blink      <= 1'b0;
      blink_cnt  <= '0;
    end else begin
      load <= 1'b0;
      case (state)
        RUN: begin
          if (mode_btn) begin
            state      <= SET_HR;
            run_en     <= 1'b0;
            edit_field <= 2'd1;
            blink      <= 1'b1;
            blink_cnt  <= '0;
            load_hh    <= sanitize(cur_hh, 8'h23);
            load_mm    <= sanitize(cur_mm, 8'h59);
          end
        end
        SET_HR, SET_MIN: begin
          if (abort) begin
            state      <= RUN;
            run_en     <= 1'b1;
            edit_field <= 2'd0;
            blink      <= 1'b0;
            blink_cnt  <= '0;
          end else if (mode_btn) begin
            blink_cnt <= '0;
            if (state == SET_HR) begin
              state      <= SET_MIN;
              edit_field <= 2'd2;
              blink      <= 1'b1;
            end else begin
              state      <= COMMIT;
              load       <= 1'b1;
              edit_field <= 2'd0;
              blink      <= 1'b0;
            end
          end else begin
            if (step && state == SET_HR)
              load_hh <= inc_btn ? bcd_inc(load_hh, 8'h23) : bcd_dec(load_hh, 8'h23);
            if (step && state == SET_MIN)
              load_mm <= inc_btn ? bcd_inc(load_mm, 8'h59) : bcd_dec(load_mm, 8'h59);
            // Any inc/dec pulse (even a cancelling pair) restarts the lit half-period.
            if (bump) begin
              blink     <= 1'b1;
              blink_cnt <= '0;
            end else if (blink_cnt == BLINK_LAST) begin
              blink     <= ~blink;
              blink_cnt <= '0;
            end else begin
              blink_cnt <= blink_cnt + 1'b1;
            end
          end
        end
        COMMIT: begin
          state  <= RUN;
          run_en <= 1'b1;
        end
        default: begin
          state      <= RUN;
          run_en     <= 1'b1;
          edit_field <= 2'd0;
          blink      <= 1'b0;
        end
      endcase
    end
  end

endmodule
